// File: rtl/s2p_stream.sv
// s2p_stream: collects WIDTH-bit samples into DEPTH-slot frames behind a one-deep output register.
// Optional macro S2P_BITREV_EN stores samples in bit-reversed slot order.
module s2p_stream #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_valid,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_sof,
   output logic                     o_ready,
   output logic                     o_valid,
   output logic [WIDTH*DEPTH-1:0]   o_data,
   input  logic                     i_ready,
   output logic                     o_sof_err,
   output logic [7:0]               o_frame_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   typedef logic [DEPTH-1:0][WIDTH-1:0] frame_t;

   logic [AW-1:0] cnt_q, cnt_d;
   frame_t        buf_q, buf_d;
   frame_t        data_q, data_d;
   logic          pending_q, pending_d;
   logic          valid_q, valid_d;
   logic          sof_err_q, sof_err_d;
   logic [7:0]    frame_cnt_q, frame_cnt_d;
   logic          accept;
   logic          slot_free;
   logic          complete;
   logic          load;
   logic [AW-1:0] wr_slot;

`ifdef S2P_BITREV_EN
   function automatic logic [AW-1:0] slot_map(input logic [AW-1:0] k);
      logic [AW-1:0] r;
      r = '0;
      for (int unsigned b = 0; b < AW; b++) begin
         r[b] = k[AW-1-b];
      end
      return r;
   endfunction
`else
   function automatic logic [AW-1:0] slot_map(input logic [AW-1:0] k);
      return k;
   endfunction
`endif

   assign o_ready   = reset && !pending_q;
   assign accept    = i_valid && o_ready;
   assign slot_free = !valid_q || i_ready;

   always_comb begin
      cnt_d       = cnt_q;
      buf_d       = buf_q;
      sof_err_d   = 1'b0;
      complete    = 1'b0;
      wr_slot     = '0;
      if (accept) begin
         // A start-of-frame restarts collection at slot 0 in both slot orders.
         if (i_sof) begin
            wr_slot   = '0;
            cnt_d     = AW'(1);
            sof_err_d = (cnt_q != '0);
         end else begin
            wr_slot  = slot_map(cnt_q);
            cnt_d    = cnt_q + AW'(1);
            complete = (cnt_q == LAST);
         end
         buf_d[wr_slot] = i_data;
      end

      load = (complete || pending_q) && slot_free;

      pending_d = pending_q;
      if (complete && !slot_free) begin
         pending_d = 1'b1;
      end else if (load) begin
         pending_d = 1'b0;
      end

      data_d      = data_q;
      valid_d     = valid_q;
      frame_cnt_d = frame_cnt_q;
      if (load) begin
         data_d      = buf_d;
         valid_d     = 1'b1;
         frame_cnt_d = frame_cnt_q + 8'd1;
      end else if (valid_q && i_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q       <= '0;
         buf_q       <= '0;
         data_q      <= '0;
         pending_q   <= 1'b0;
         valid_q     <= 1'b0;
         sof_err_q   <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         cnt_q       <= cnt_d;
         buf_q       <= buf_d;
         data_q      <= data_d;
         pending_q   <= pending_d;
         valid_q     <= valid_d;
         sof_err_q   <= sof_err_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign o_valid     = valid_q;
   assign o_data      = data_q;
   assign o_sof_err   = sof_err_q;
   assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_s2p_stream.sv
// Self-checking bench for s2p_stream: directed scenarios plus random traffic against a frame-level model.
`timescale 1ns/1ps
module tb_s2p_stream;

   localparam int W   = 10;
   localparam int D   = 64;
   localparam int LG  = 6;
   localparam int FW  = W * D;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_valid, i_sof, i_ready;
   logic [W-1:0]  i_data;
   logic          o_ready, o_valid, o_sof_err;
   logic [FW-1:0] o_data;
   logic [7:0]    o_frame_cnt;

   int checks   = 0;
   int failures = 0;

   // Frame-level reference state
   logic [W-1:0]  samples[$];
   logic [FW-1:0] waiting[$];
   logic          exp_ready, exp_valid, exp_err;
   logic [7:0]    exp_cnt;
   logic [FW-1:0] exp_data;

   s2p_stream #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .reset(rst_n), .i_valid(i_valid), .i_data(i_data), .i_sof(i_sof),
      .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready),
      .o_sof_err(o_sof_err), .o_frame_cnt(o_frame_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   function automatic int map_slot(input int k);
      int r;
`ifdef S2P_BITREV_EN
      int v;
      v = k;
      r = 0;
      for (int b = 0; b < LG; b++) begin
         r = r * 2 + (v % 2);
         v = v / 2;
      end
`else
      r = k;
`endif
      return r;
   endfunction

   function automatic logic [FW-1:0] build_frame();
      logic [FW-1:0] f;
      f = '0;
      for (int k = 0; k < D; k++) f[map_slot(k)*W +: W] = samples[k];
      return f;
   endfunction

   task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      samples.delete();
      waiting.delete();
      exp_valid = 1'b0;
      exp_data  = '0;
      exp_cnt   = 8'd0;
      exp_err   = 1'b0;
      exp_ready = 1'b0;
   endtask

   task automatic check_outputs();
      chk("o_ready",     FW'(o_ready),     FW'(exp_ready));
      chk("o_valid",     FW'(o_valid),     FW'(exp_valid));
      chk("o_sof_err",   FW'(o_sof_err),   FW'(exp_err));
      chk("o_frame_cnt", FW'(o_frame_cnt), FW'(exp_cnt));
      chk("o_data",      o_data,           exp_data);
   endtask

   // One clock: advance the model with the inputs present at the edge, then compare.
   task automatic cycle(output logic acc);
      logic free;
      acc = 1'b0;
      @(posedge clk);
      if (rst_n) begin
         acc     = i_valid && exp_ready;
         exp_err = 1'b0;
         if (acc) begin
            if (i_sof) begin
               exp_err = (samples.size() != 0);
               samples.delete();
            end
            samples.push_back(i_data);
            if (samples.size() == D) begin
               waiting.push_back(build_frame());
               samples.delete();
            end
         end
         free = !exp_valid || i_ready;
         if (waiting.size() != 0 && free) begin
            exp_data  = waiting.pop_front();
            exp_valid = 1'b1;
            exp_cnt   = exp_cnt + 8'd1;
         end else if (exp_valid && i_ready) begin
            exp_valid = 1'b0;
         end
         exp_ready = (waiting.size() == 0);
      end
      #1;
      check_outputs();
   endtask

   task automatic send(input logic [W-1:0] d, input logic sof);
      logic acc;
      int   n;
      n       = 0;
      i_valid = 1'b1;
      i_data  = d;
      i_sof   = sof;
      do begin
         cycle(acc);
         n++;
      end while (!acc && n < 200);
      chk("send_accepted", FW'(acc), FW'(1'b1));
      i_valid = 1'b0;
      i_sof   = 1'b0;
   endtask

   task automatic release_reset();
      rst_n     = 1'b1;
      exp_ready = 1'b1;
      #1;
      chk("ready_after_release", FW'(o_ready), FW'(1'b1));
   endtask

   initial begin
      logic          acc;
      logic [W-1:0]  first_d;
      int            stalls;
      logic [FW-1:0] zero;
      zero    = '0;
      rst_n   = 1'b0;
      i_valid = 1'b0;
      i_sof   = 1'b0;
      i_ready = 1'b0;
      i_data  = '0;
      model_reset();
      #2;
      check_outputs();
      repeat (3) cycle(acc);
      release_reset();

      // Single frame 0..63 with downstream always ready
      i_ready = 1'b1;
      for (int n = 0; n < D; n++) send(W'(n), 1'b0);
      chk("req031_valid", FW'(o_valid), FW'(1'b1));
`ifdef S2P_BITREV_EN
      chk("req031_slot1",  FW'(o_data[1*W +: W]),  FW'(32));
      chk("req031_slot2",  FW'(o_data[2*W +: W]),  FW'(16));
`else
      chk("req031_slot1",  FW'(o_data[1*W +: W]),  FW'(1));
      chk("req031_slot2",  FW'(o_data[2*W +: W]),  FW'(2));
`endif
      chk("req031_slot63", FW'(o_data[63*W +: W]), FW'(63));
      chk("req031_cnt",    FW'(o_frame_cnt),       FW'(1));
      cycle(acc);
      chk("req031_valid_falls", FW'(o_valid), FW'(1'b0));

      // Two frames into a stalled downstream
      i_ready = 1'b0;
      for (int n = 0; n < 2 * D; n++) send(W'(n), 1'b0);
      chk("req032_stall", FW'(o_ready), FW'(1'b0));
      i_valid = 1'b1;
      i_data  = W'(555);
      repeat (10) begin
         cycle(acc);
         chk("req032_no_accept", FW'(acc), FW'(1'b0));
      end
      chk("req032_hold_slot0",  FW'(o_data[0 +: W]),    FW'(0));
      chk("req032_hold_slot63", FW'(o_data[63*W +: W]), FW'(63));
      i_ready = 1'b1;
      cycle(acc);
      chk("req032_f2_slot0",  FW'(o_data[0 +: W]),    FW'(64));
      chk("req032_f2_slot63", FW'(o_data[63*W +: W]), FW'(127));
      chk("req032_ready_back", FW'(o_ready), FW'(1'b1));
      chk("req032_cnt", FW'(o_frame_cnt), FW'(3));
      send(W'(555), 1'b0);

      // Start-of-frame discards a 20-sample partial frame
      for (int n = 0; n < 19; n++) send(W'($urandom), 1'b0);
      send(W'(100), 1'b1);
      chk("req033_err_pulse", FW'(o_sof_err), FW'(1'b1));
      for (int n = 0; n < D - 1; n++) begin
         send(W'($urandom), 1'b0);
         if (n == 0) chk("req033_err_low", FW'(o_sof_err), FW'(1'b0));
      end
      chk("req033_valid", FW'(o_valid), FW'(1'b1));
      chk("req033_slot0", FW'(o_data[0 +: W]), FW'(100));

      // Asynchronous reset in the middle of a frame
      for (int n = 0; n < 30; n++) send(W'($urandom), 1'b0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outputs();
      chk("req034_data_zero", o_data, zero);
      repeat (2) cycle(acc);
      release_reset();
      first_d = W'($urandom);
      send(first_d, 1'b0);
      for (int n = 1; n < D; n++) send(W'($urandom), 1'b0);
      chk("req034_slot0", FW'(o_data[0 +: W]), FW'(first_d));
      chk("req034_cnt",   FW'(o_frame_cnt),    FW'(1));

      // Random traffic with random backpressure and stray start-of-frame markers
      for (int n = 0; n < 3000; n++) begin
         i_valid = ($urandom % 4) != 0;
         i_ready = ($urandom % 3) != 0;
         i_sof   = ($urandom % 50) == 0;
         i_data  = W'($urandom);
         cycle(acc);
      end
      i_valid = 1'b0;
      i_sof   = 1'b0;

      // 256 back-to-back frames: counter wraps, input never stalls
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outputs();
      @(posedge clk);
      #1;
      release_reset();
      i_ready = 1'b1;
      stalls  = 0;
      for (int n = 0; n < 256 * D; n++) begin
         send(W'($urandom), 1'b0);
         if (!o_ready) stalls++;
      end
      chk("req035_no_stall", FW'(stalls), FW'(0));
      chk("req035_wrap",     FW'(o_frame_cnt), FW'(0));
      chk("req035_valid",    FW'(o_valid), FW'(1'b1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/s2p_stream.md
S2P_STREAM -- requirements
Module: s2p_stream

Interface
REQ-001 Parameter WIDTH, default 10, sample width in bits (>=1).
REQ-002 Parameter DEPTH, default 64, samples per parallel frame (power of two, 2..256).
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 reset  in  1  reset is asynchronous and active-low.
REQ-005 i_valid  in  1  input sample valid.
REQ-006 i_data  in  WIDTH  input sample.
REQ-007 i_sof  in  1  start-of-frame marker, qualified by i_valid.
REQ-008 o_ready  out  1  block accepts a sample this cycle.
REQ-009 o_valid  out  1  o_data holds a complete frame.
REQ-010 o_data  out  WIDTH*DEPTH  packed frame, slot k at bits [k*WIDTH +: WIDTH].
REQ-011 i_ready  in  1  downstream accepts frame.
REQ-012 o_sof_err  out  1  one-cycle pulse, partial frame discarded by i_sof.
REQ-013 o_frame_cnt  out  8  count of frames handed off, wraps 255->0.

Function
REQ-014 Sample accepted iff i_valid && o_ready at a rising edge.
REQ-015 Collect counter cnt (log2 DEPTH bits) holds the slot for the next accepted sample; increments per accept, wraps DEPTH-1 -> 0.
REQ-016 Accepted sample written to collect-buffer slot cnt (slot mapping per REQ-029).
REQ-017 i_sof on an accepted sample: sample goes to slot 0, cnt becomes 1; if cnt was nonzero, o_sof_err pulses the next cycle and the partial frame is discarded.
REQ-018 Output slot free = !o_valid || i_ready.
REQ-019 On the accept filling slot DEPTH-1 with output slot free: collect buffer incl. that sample loads o_data; o_valid = 1 the next cycle (latency 1 cycle from last accept).
REQ-020 Same event with output slot not free: set internal pending flag; collect buffer holds the complete frame.
REQ-021 o_ready = !pending, gated to 0 while reset is asserted; no other stall source.
REQ-022 While pending and output slot free: collect buffer loads o_data, o_valid = 1, pending clears; o_ready returns high the following cycle.
REQ-023 o_valid && i_ready with no new frame loading: o_valid falls the next cycle.
REQ-024 o_valid && !i_ready: o_data and o_valid held stable.
REQ-025 Handoff and new-frame completion in the same cycle: frame replaces o_data, o_valid stays 1, no gap; full throughput with i_ready held at 1.
REQ-026 o_frame_cnt increments on each load into o_data.
REQ-027 Untouched o_data bits never change except on a frame load.

Reset
REQ-028 While reset is low: cnt=0, pending=0, o_valid=0, o_data=0, o_sof_err=0, o_frame_cnt=0, o_ready=0; o_ready=1 in the first cycle after release; a partial frame in progress at reset is lost.

Configuration
REQ-029 Macro S2P_BITREV_EN: when defined, the sample accepted at counter value k is stored at slot bitrev(k) over log2(DEPTH) bits (FFT input order); when undefined, it is stored at slot k (natural order).
REQ-030 The macro changes only slot mapping; handshake, latency, and counters are identical in both builds.

Verification
REQ-031 WIDTH=10, DEPTH=64, i_ready=1, samples 0..63 back-to-back -> o_valid 1 cycle after 64th accept; natural build: slot k = k; S2P_BITREV_EN build: slot 1 = 32, slot 2 = 16, slot 63 = 63; o_frame_cnt = 1.
REQ-032 Two frames back-to-back, i_ready=0 until 10 cycles after second frame completes -> o_ready low from cycle after 128th accept until 1 cycle after i_ready rises; frame 1 = 0..63 held, then frame 2 = 64..127 loaded; no sample lost.
REQ-033 i_sof with sample 100 after 20 accepts -> o_sof_err one-cycle pulse; next frame slot 0 = 100, 63 further samples complete it.
REQ-034 reset pulsed low after 30 accepts -> all outputs 0 immediately; after release 64 new samples produce a frame starting at slot 0, o_frame_cnt = 1.
REQ-035 256 complete frames with i_ready=1 -> o_frame_cnt wraps to 0; o_valid continuously high from first frame on while input is back-to-back.
